// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch queue: entry layout, PC increment and pointer sizing.
package fetch_pkg;

    localparam int PC_STEP    = 4;
    localparam int FQ_PC_W    = 32;
    localparam int FQ_INSTR_W = 32;

    typedef struct packed {
        logic [FQ_PC_W-1:0]    pc;
        logic [FQ_INSTR_W-1:0] instr;
        logic                  done;
    } fq_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue_ptr_ring.sv
// Modulo-DEPTH pointer used for the head, tail and fill positions of the fetch queue.
module fq_ptr_ring
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ptr <= '0;
        else if (clear)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch buffer between the PC register and decode; absorbs variable memory latency.
// Optional perf counters are enabled with FETCH_QUEUE_PERF_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int SIZE  = FQ_PC_W,
    parameter int DEPTH = 4,
    parameter int ILEN  = FQ_INSTR_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [SIZE-1:0] PCF,
    input  logic            PCValidF,
    output logic            StallF,
    output logic            ImemReq,
    output logic [SIZE-1:0] ImemAddr,
    input  logic            ImemReady,
    input  logic            ImemRValid,
    input  logic [ILEN-1:0] ImemRData,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            ValidD,
    output logic [ILEN-1:0] InstrD,
    output logic [SIZE-1:0] PCD,
    output logic [SIZE-1:0] PCPlus4D
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     PerfStallCycles,
    output logic [31:0]     PerfFlushDrops,
    output logic [31:0]     PerfDelivered
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    // Stale responses can pile up across back-to-back flushes, so this counter gets extra headroom.
    localparam int SW = CW + 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fq_entry_t      entries [DEPTH];
    logic [PW-1:0]  head, tail, fill;
    logic [CW-1:0]  count, inflight;
    logic [SW-1:0]  stale, pending;
    logic           accept, pop, resp_drop, resp_fill, flush_resp;

    assign ImemReq    = PCValidF & ~FlushD & (count < FULL);
    assign ImemAddr   = PCF;
    assign accept     = ImemReq & ImemReady;
    assign StallF     = PCValidF & ((count == FULL) | ~ImemReady);

    assign ValidD     = entries[head].done & ~FlushD;
    assign pop        = ValidD & ~StallD;
    assign InstrD     = ValidD ? ILEN'(entries[head].instr) : '0;
    assign PCD        = ValidD ? SIZE'(entries[head].pc) : '0;
    assign PCPlus4D   = ValidD ? SIZE'(entries[head].pc) + SIZE'(PC_STEP) : '0;

    assign pending    = SW'(inflight) + stale;
    assign flush_resp = ImemRValid & (pending != '0);
    assign resp_drop  = ImemRValid & (stale != '0);
    assign resp_fill  = ImemRValid & (stale == '0) & (inflight != '0) & ~FlushD;

    fq_ptr_ring #(.DEPTH(DEPTH)) u_head (.CLK(CLK), .RST(RST), .clear(FlushD), .inc(pop),       .ptr(head));
    fq_ptr_ring #(.DEPTH(DEPTH)) u_tail (.CLK(CLK), .RST(RST), .clear(FlushD), .inc(accept),    .ptr(tail));
    fq_ptr_ring #(.DEPTH(DEPTH)) u_fill (.CLK(CLK), .RST(RST), .clear(FlushD), .inc(resp_fill), .ptr(fill));

    // On flush every response still owed by memory becomes stale, minus one arriving right now.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count    <= '0;
            inflight <= '0;
            stale    <= '0;
        end else if (FlushD) begin
            count    <= '0;
            inflight <= '0;
            stale    <= pending - (flush_resp ? SW'(1) : SW'(0));
        end else begin
            count    <= count + CW'(accept) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(resp_fill);
            if (resp_drop)
                stale <= stale - SW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else if (FlushD) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i].done <= 1'b0;
        end else begin
            if (accept) begin
                entries[tail].pc   <= FQ_PC_W'(PCF);
                entries[tail].done <= 1'b0;
            end
            if (resp_fill) begin
                entries[fill].instr <= FQ_INSTR_W'(ImemRData);
                entries[fill].done  <= 1'b1;
            end
            if (pop)
                entries[head].done <= 1'b0;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] flush_drop_inc;

    // Completed entries are counted at the flush; in-flight ones are counted when their data is dropped.
    always_comb begin
        flush_drop_inc = 32'd0;
        if (FlushD)
            flush_drop_inc = 32'(count - inflight) + 32'(flush_resp);
        else if (resp_drop)
            flush_drop_inc = 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PerfStallCycles <= '0;
            PerfFlushDrops  <= '0;
            PerfDelivered   <= '0;
        end else begin
            PerfStallCycles <= sat_add32(PerfStallCycles, 32'(StallF));
            PerfFlushDrops  <= sat_add32(PerfFlushDrops, flush_drop_inc);
            PerfDelivered   <= sat_add32(PerfDelivered, 32'(pop));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: each cycle drives inputs, then compares outputs to hand-computed values.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PCF;
    logic        PCValidF;
    logic        StallF;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic        StallD;
    logic        FlushD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] PerfStallCycles;
    logic [31:0] PerfFlushDrops;
    logic [31:0] PerfDelivered;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fetch_queue #(.SIZE(32), .DEPTH(4), .ILEN(32)) dut (
        .CLK(CLK), .RST(RST), .PCF(PCF), .PCValidF(PCValidF), .StallF(StallF),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData), .StallD(StallD), .FlushD(FlushD),
        .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
`ifdef FETCH_QUEUE_PERF_EN
        , .PerfStallCycles(PerfStallCycles), .PerfFlushDrops(PerfFlushDrops),
        .PerfDelivered(PerfDelivered)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic pcv, input logic [31:0] pc, input logic rdy,
                                 input logic rv, input logic [31:0] rdata,
                                 input logic stall_d, input logic flush_d);
        PCValidF   = pcv;
        PCF        = pc;
        ImemReady  = rdy;
        ImemRValid = rv;
        ImemRData  = rdata;
        StallD     = stall_d;
        FlushD     = flush_d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic expectHead(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        checkOutput({tag, ".valid"}, 32'(ValidD), 32'd1);
        checkOutput({tag, ".instr"}, InstrD, instr);
        checkOutput({tag, ".pc"}, PCD, pc);
        checkOutput({tag, ".pc4"}, PCPlus4D, pc + 32'd4);
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        checkOutput("rst.valid", 32'(ValidD), 32'd0);
        checkOutput("rst.instr", InstrD, 32'd0);
        checkOutput("rst.pc", PCD, 32'd0);
        checkOutput("rst.pc4", PCPlus4D, 32'd0);
        checkOutput("rst.req", 32'(ImemReq), 32'd0);
        tick;
        tick;
        RST = 1'b0;

        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1.req", 32'(ImemReq), 32'd1);
        checkOutput("t1.addr", ImemAddr, 32'h100);
        checkOutput("t1.stallf", 32'(StallF), 32'd0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
        checkOutput("t1.early", 32'(ValidD), 32'd0);
        tick;
        idle;
        expectHead("t1.head", 32'h100, 32'h0050_0093);
        tick;
        idle;
        checkOutput("t1.empty", 32'(ValidD), 32'd0);
        tick;

        $display("[TB] backpressure");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'(4 * k), 1'b1, k > 0, 32'h1000_0000 + 32'(k - 1), 1'b1, 1'b0);
            checkOutput("t2.req", 32'(ImemReq), 32'd1);
            tick;
        end
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h1000_0003, 1'b1, 1'b0);
        checkOutput("t2.full.stallf", 32'(StallF), 32'd1);
        checkOutput("t2.full.req", 32'(ImemReq), 32'd0);
        expectHead("t2.stalled", 32'h0, 32'h1000_0000);
        tick;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t2.popfull.req", 32'(ImemReq), 32'd0);
        expectHead("t2.d0", 32'h0, 32'h1000_0000);
        tick;
        for (int k = 1; k < 4; k++) begin
            idle;
            expectHead("t2.dn", 32'(4 * k), 32'h1000_0000 + 32'(k));
            tick;
        end
        idle;
        checkOutput("t2.drained", 32'(ValidD), 32'd0);
        tick;

        $display("[TB] memory not ready");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("t3.stallf", 32'(StallF), 32'd1);
            checkOutput("t3.valid", 32'(ValidD), 32'd0);
            tick;
        end
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t3.ready.stallf", 32'(StallF), 32'd0);
        checkOutput("t3.ready.req", 32'(ImemReq), 32'd1);
        tick;
        applyStimulus(1'b1, 32'h24, 1'b1, 1'b1, 32'hAAAA_0020, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0024, 1'b0, 1'b0);
        expectHead("t3.d20", 32'h20, 32'hAAAA_0020);
        tick;
        idle;
        expectHead("t3.d24", 32'h24, 32'hAAAA_0024);
        tick;
        idle;
        checkOutput("t3.empty", 32'(ValidD), 32'd0);
        tick;

        $display("[TB] flush with two in flight");
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t4.flush.req", 32'(ImemReq), 32'd0);
        checkOutput("t4.flush.valid", 32'(ValidD), 32'd0);
        tick;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'hDEAD_0040, 1'b0, 1'b0);
        checkOutput("t4.newreq", 32'(ImemReq), 32'd1);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0044, 1'b0, 1'b0);
        checkOutput("t4.stale1", 32'(ValidD), 32'd0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0020_0200, 1'b0, 1'b0);
        checkOutput("t4.stale2", 32'(ValidD), 32'd0);
        tick;
        idle;
        expectHead("t4.d200", 32'h200, 32'h0020_0200);
        tick;
        idle;
        checkOutput("t4.empty", 32'(ValidD), 32'd0);
        tick;

        $display("[TB] flush with response and pop");
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, 32'h304, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b1);
        checkOutput("t5.flush.valid", 32'(ValidD), 32'd0);
        checkOutput("t5.flush.instr", InstrD, 32'd0);
        tick;
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5.after.valid", 32'(ValidD), 32'd0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0044, 1'b0, 1'b0);
        tick;
        idle;
        expectHead("t5.d400", 32'h400, 32'h0000_0044);
        tick;

        $display("[TB] async reset mid-burst");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h500 + 32'(4 * k), 1'b1, k > 0, 32'h55 + 32'(k - 1), 1'b1, 1'b0);
            tick;
        end
        applyStimulus(1'b1, 32'h510, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("t6.full.stallf", 32'(StallF), 32'd1);
        expectHead("t6.pre", 32'h500, 32'h55);
        #1;
        RST = 1'b1;
        #1;
        checkOutput("t6.rst.valid", 32'(ValidD), 32'd0);
        checkOutput("t6.rst.pc", PCD, 32'd0);
        checkOutput("t6.rst.stallf", 32'(StallF), 32'd0);
        checkOutput("t6.rst.req", 32'(ImemReq), 32'd1);
`ifdef FETCH_QUEUE_PERF_EN
        checkOutput("t6.rst.perfstall", PerfStallCycles, 32'd0);
        checkOutput("t6.rst.perfdrop", PerfFlushDrops, 32'd0);
        checkOutput("t6.rst.perfdeliv", PerfDelivered, 32'd0);
`endif
        tick;
        RST = 1'b0;
        applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0066, 1'b0, 1'b0);
        tick;
        idle;
        expectHead("t6.d600", 32'h600, 32'h0000_0066);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
